vid_colour_bbox: RTL and testbench
==================================

# vid_colour_bbox

Streaming colour-blob detector. It consumes the 24-bit clocked-video output of the system's interlaced-to-clocked stage (`vid_data`, `vid_datavalid`, `vid_h_sync`, `vid_v_sync`) on the VGA pixel clock. Each frame it finds the bounding box and pixel count of pixels matching a fixed RGB threshold, then hands the result to a consumer (the report sequencer ahead of the ESP UART) over a valid/ready handshake. Video is passed through with one cycle of delay.

## Interface
- `X_W`, 11: column counter width
- `Y_W`, 10: row counter width
- `R_MIN`, 8'd160: minimum red for a match
- `G_MAX`, 8'd90: maximum green for a match
- `B_MAX`, 8'd90: maximum blue for a match
- `MIN_PIXELS`, 16: minimum matched-pixel count for `res_found`=1
- `clk`  in  1  pixel clock (the clock driving the VGA video output); only clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  detection enable; sampled at frame start
- `vid_data`  in  24  pixel `{R[23:16],G[15:8],B[7:0]}`
- `vid_datavalid`  in  1  active-video pixel qualifier
- `vid_h_sync`, `vid_v_sync`  in  1 each  active-high syncs
- `out_data`  out  24  delayed (optionally overlaid) pixel
- `out_datavalid`, `out_h_sync`, `out_v_sync`  out  1 each  delayed qualifiers
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_found`  out  1  count ≥ MIN_PIXELS
- `res_xmin`, `res_xmax`  out  X_W  box columns
- `res_ymin`, `res_ymax`  out  Y_W  box rows
- `res_count`  out  X_W+Y_W  matched pixels, saturating
- `res_overrun`  out  1  sticky: an unaccepted result was overwritten

## Operation
- Match: `R>=R_MIN && G<=G_MAX && B<=B_MAX && vid_datavalid && frame_en`. Comparisons are unsigned 8-bit.
- Stage 1 registers the pixel, its match bit, and the current `x`/`y`. Stage 2 updates the accumulators.
- `x` increments on each `vid_datavalid` cycle and clears on the `vid_datavalid` falling edge.
- `y` increments on the `vid_datavalid` falling edge and clears at frame start.
- `x` and `y` saturate at all-ones; they never wrap.
- Frame start is the `vid_v_sync` rising edge, detected against a registered copy.
- FSM states:
  - IDLE (after reset): waits for the first frame start; nothing is accumulated. Goes to ACCUM and samples `enable` into `frame_en`.
  - ACCUM: each match updates xmin/xmax/ymin/ymax and increments count (saturating). On the next frame start, goes to PUBLISH.
  - PUBLISH (1 cycle): loads the result registers and clears the accumulators (min to all-ones, max to 0, count to 0). Re-samples `enable` and returns to ACCUM.
- Result contents:
  - If count ≥ MIN_PIXELS: `res_found`=1 and the box fields are loaded.
  - Otherwise: `res_found`=0, all box fields are 0, and `res_count` still holds the actual count.
- Handshake:
  - `res_valid` sets in PUBLISH.
  - `res_valid` clears on the cycle after `res_valid&&res_ready`.
  - Result fields are stable while `res_valid`=1.
- Overwrite: if PUBLISH occurs while `res_valid`=1 and `res_ready`=0, the new result replaces the old one, `res_valid` stays 1, and `res_overrun` sets. `res_overrun` clears only on reset.
- PUBLISH coinciding with a handshake: the new result wins, `res_valid` stays 1, and there is no overrun.
- `enable`=0 at frame start: the frame publishes with count 0 and `res_found`=0.
- Reset at any time:
  - All outputs go to 0, the FSM goes to IDLE, and accumulators clear.
  - The partial frame in progress is never published.

## Timing
- Video path: exactly 1 cycle of latency, with all four outputs aligned. Out-of-reset values are 0.
- Match to accumulator update: 2 cycles after the pixel is on the inputs.
- `vid_v_sync` rising at input cycle k:
  - Edge detected at k+1 (PUBLISH).
  - `res_valid`=1 at k+2.
- Active video ends at least 2 cycles before `vid_v_sync` rises, so the last pixel is always counted.
- The accumulators hold one frame; there is no further buffering.

## Configuration
- `VID_BBOX_OVERLAY_EN` defined:
  - Matched pixels on `out_data` are replaced by 24'h00FF00.
  - Pixels on the previous frame's published box perimeter (if `res_found`) are replaced by 24'hFFFF00.
  - Latency is unchanged at 1 cycle.
- Undefined: `out_data` is the unmodified delayed `vid_data`, and the overlay logic is absent.

## Test plan
- 640×480 frame, red 24'hFF0000 square at x 100–139, y 50–89; `enable`=1; `res_ready`=1.
  - Next frame start gives `res_valid` pulse with found=1, box 100/139/50/89, count=1600.
- Frame with 15 red pixels: found=0, box fields 0, count=15.
- Two frames with `res_ready`=0:
  - First result stays held.
  - Second frame start overwrites it and sets `res_overrun`=1.
  - `res_valid` stays 1.
- `reset` pulse mid-frame with red pixels:
  - All outputs go to 0 immediately.
  - The first frame start after release publishes nothing (IDLE to ACCUM).
  - The following frame publishes correctly.
- Pixel 24'hA05A5A (on-threshold) and 24'h9F5A5A (off by one red LSB): exactly one is counted.
- With `VID_BBOX_OVERLAY_EN`: for a red pixel at input cycle n, `out_data`=24'h00FF00 at n+1, and `out_datavalid` is aligned with it.

Source files
------------

// File: rtl/vid_colour_bbox.sv
// Streaming colour-blob detector: per-frame bounding box and pixel count of threshold-matching pixels.
// Optional build macro VID_BBOX_OVERLAY_EN paints matches green and the last published box yellow.

module vid_colour_bbox #(
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  G_MAX      = 8'd90,
    parameter logic [7:0]  B_MAX      = 8'd90,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [23:0]            vid_data,
    input  logic                   vid_datavalid,
    input  logic                   vid_h_sync,
    input  logic                   vid_v_sync,
    output logic [23:0]            out_data,
    output logic                   out_datavalid,
    output logic                   out_h_sync,
    output logic                   out_v_sync,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_found,
    output logic [X_W-1:0]         res_xmin,
    output logic [X_W-1:0]         res_xmax,
    output logic [Y_W-1:0]         res_ymin,
    output logic [Y_W-1:0]         res_ymax,
    output logic [X_W+Y_W-1:0]     res_count,
    output logic                   res_overrun
);

    localparam int unsigned CNT_W = X_W + Y_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    function automatic logic [X_W-1:0] inc_x(input logic [X_W-1:0] v);
        return (&v) ? v : v + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] inc_y(input logic [Y_W-1:0] v);
        return (&v) ? v : v + Y_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [23:0]      pix_q;
    logic             dv_q;
    logic             hs_q;
    logic             vs_q;
    logic             match_q;
    logic [X_W-1:0]   px_x_q;
    logic [Y_W-1:0]   px_y_q;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;

    logic [1:0]       state_q, state_d;
    logic             frame_en_q, frame_en_d;

    logic [X_W-1:0]   acc_xmin_q, acc_xmin_d;
    logic [X_W-1:0]   acc_xmax_q, acc_xmax_d;
    logic [Y_W-1:0]   acc_ymin_q, acc_ymin_d;
    logic [Y_W-1:0]   acc_ymax_q, acc_ymax_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;

    logic             res_valid_q, res_valid_d;
    logic             res_found_q, res_found_d;
    logic [X_W-1:0]   res_xmin_q, res_xmin_d;
    logic [X_W-1:0]   res_xmax_q, res_xmax_d;
    logic [Y_W-1:0]   res_ymin_q, res_ymin_d;
    logic [Y_W-1:0]   res_ymax_q, res_ymax_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_overrun_q, res_overrun_d;

    logic match_c;
    logic frame_start_c;
    logic line_end_c;

    assign match_c = vid_datavalid && frame_en_q
                     && (vid_data[23:16] >= R_MIN)
                     && (vid_data[15:8]  <= G_MAX)
                     && (vid_data[7:0]   <= B_MAX);

    // Frame start and line end are edges of the live inputs against their stage-1 copies.
    assign frame_start_c = vid_v_sync && !vs_q;
    assign line_end_c    = !vid_datavalid && dv_q;

    always_comb begin
        x_d = x_q;
        if (vid_datavalid) begin
            x_d = inc_x(x_q);
        end else if (line_end_c) begin
            x_d = '0;
        end
    end

    always_comb begin
        y_d = y_q;
        if (frame_start_c) begin
            y_d = '0;
        end else if (line_end_c) begin
            y_d = inc_y(y_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q   <= '0;
            dv_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            match_q <= 1'b0;
            px_x_q  <= '0;
            px_y_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            pix_q   <= vid_data;
            dv_q    <= vid_datavalid;
            hs_q    <= vid_h_sync;
            vs_q    <= vid_v_sync;
            match_q <= match_c;
            px_x_q  <= x_q;
            px_y_q  <= y_q;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_en_d = frame_en_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_c) begin
                    state_d    = ST_ACCUM;
                    frame_en_d = enable;
                end
            end
            ST_ACCUM: begin
                if (frame_start_c) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d    = ST_ACCUM;
                frame_en_d = enable;
            end
            default: begin
                state_d    = ST_IDLE;
                frame_en_d = 1'b0;
            end
        endcase
    end

    // The publish cycle restarts from the cleared state, so a match arriving then still counts.
    always_comb begin
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        acc_count_d = acc_count_q;
        if (state_q == ST_PUBLISH) begin
            acc_xmin_d  = '1;
            acc_xmax_d  = '0;
            acc_ymin_d  = '1;
            acc_ymax_d  = '0;
            acc_count_d = '0;
        end
        if (match_q && (state_q != ST_IDLE)) begin
            if (px_x_q < acc_xmin_d) acc_xmin_d = px_x_q;
            if (px_x_q > acc_xmax_d) acc_xmax_d = px_x_q;
            if (px_y_q < acc_ymin_d) acc_ymin_d = px_y_q;
            if (px_y_q > acc_ymax_d) acc_ymax_d = px_y_q;
            acc_count_d = inc_cnt(acc_count_d);
        end
    end

    always_comb begin
        res_valid_d   = res_valid_q;
        res_found_d   = res_found_q;
        res_xmin_d    = res_xmin_q;
        res_xmax_d    = res_xmax_q;
        res_ymin_d    = res_ymin_q;
        res_ymax_d    = res_ymax_q;
        res_count_d   = res_count_q;
        res_overrun_d = res_overrun_q;
        if (state_q == ST_PUBLISH) begin
            res_valid_d = 1'b1;
            res_count_d = acc_count_q;
            if (acc_count_q >= CNT_W'(MIN_PIXELS)) begin
                res_found_d = 1'b1;
                res_xmin_d  = acc_xmin_q;
                res_xmax_d  = acc_xmax_q;
                res_ymin_d  = acc_ymin_q;
                res_ymax_d  = acc_ymax_q;
            end else begin
                res_found_d = 1'b0;
                res_xmin_d  = '0;
                res_xmax_d  = '0;
                res_ymin_d  = '0;
                res_ymax_d  = '0;
            end
            if (res_valid_q && !res_ready) begin
                res_overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            frame_en_q    <= 1'b0;
            acc_xmin_q    <= '1;
            acc_xmax_q    <= '0;
            acc_ymin_q    <= '1;
            acc_ymax_q    <= '0;
            acc_count_q   <= '0;
            res_valid_q   <= 1'b0;
            res_found_q   <= 1'b0;
            res_xmin_q    <= '0;
            res_xmax_q    <= '0;
            res_ymin_q    <= '0;
            res_ymax_q    <= '0;
            res_count_q   <= '0;
            res_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_en_q    <= frame_en_d;
            acc_xmin_q    <= acc_xmin_d;
            acc_xmax_q    <= acc_xmax_d;
            acc_ymin_q    <= acc_ymin_d;
            acc_ymax_q    <= acc_ymax_d;
            acc_count_q   <= acc_count_d;
            res_valid_q   <= res_valid_d;
            res_found_q   <= res_found_d;
            res_xmin_q    <= res_xmin_d;
            res_xmax_q    <= res_xmax_d;
            res_ymin_q    <= res_ymin_d;
            res_ymax_q    <= res_ymax_d;
            res_count_q   <= res_count_d;
            res_overrun_q <= res_overrun_d;
        end
    end

    assign out_datavalid = dv_q;
    assign out_h_sync    = hs_q;
    assign out_v_sync    = vs_q;

    assign res_valid   = res_valid_q;
    assign res_found   = res_found_q;
    assign res_xmin    = res_xmin_q;
    assign res_xmax    = res_xmax_q;
    assign res_ymin    = res_ymin_q;
    assign res_ymax    = res_ymax_q;
    assign res_count   = res_count_q;
    assign res_overrun = res_overrun_q;

`ifdef VID_BBOX_OVERLAY_EN
    // Overlay works on stage-1 registers only, so the video latency stays at one cycle.
    logic in_x_span;
    logic in_y_span;
    logic on_border;

    assign in_x_span = (px_x_q >= res_xmin_q) && (px_x_q <= res_xmax_q);
    assign in_y_span = (px_y_q >= res_ymin_q) && (px_y_q <= res_ymax_q);
    assign on_border = res_found_q && dv_q
                       && ((((px_x_q == res_xmin_q) || (px_x_q == res_xmax_q)) && in_y_span)
                        || (((px_y_q == res_ymin_q) || (px_y_q == res_ymax_q)) && in_x_span));

    always_comb begin
        out_data = pix_q;
        if (match_q) begin
            out_data = 24'h00FF00;
        end else if (on_border) begin
            out_data = 24'hFFFF00;
        end
    end
`else
    assign out_data = pix_q;
`endif

endmodule

// File: tb/tb_vid_colour_bbox.sv
// Self-checking bench for vid_colour_bbox: small frames, randomized pixels, reference model of the blob result.
// Each frame start publishes the frame driven before it; drive_frame records what appears then.

module tb_vid_colour_bbox;

    localparam int COLS = 40;
    localparam int ROWS = 20;

    typedef struct {
        logic found;
        int   xmin;
        int   xmax;
        int   ymin;
        int   ymax;
        int   count;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] vid_data;
    logic        vid_datavalid;
    logic        vid_h_sync;
    logic        vid_v_sync;
    logic [23:0] out_data;
    logic        out_datavalid;
    logic        out_h_sync;
    logic        out_v_sync;
    logic        res_valid;
    logic        res_ready;
    logic        res_found;
    logic [10:0] res_xmin;
    logic [10:0] res_xmax;
    logic [9:0]  res_ymin;
    logic [9:0]  res_ymax;
    logic [20:0] res_count;
    logic        res_overrun;

    int total = 0;
    int bad   = 0;

    logic [23:0] frame_px [ROWS][COLS];

    res_t        pending;
    res_t        exp_pub;
    logic        cap_valid;
    logic        cap_valid_next;
    logic        cap_overrun;
    logic [63:0] cap_res;

    always #5 clk = ~clk;

    vid_colour_bbox dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .vid_data      (vid_data),
        .vid_datavalid (vid_datavalid),
        .vid_h_sync    (vid_h_sync),
        .vid_v_sync    (vid_v_sync),
        .out_data      (out_data),
        .out_datavalid (out_datavalid),
        .out_h_sync    (out_h_sync),
        .out_v_sync    (out_v_sync),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_found     (res_found),
        .res_xmin      (res_xmin),
        .res_xmax      (res_xmax),
        .res_ymin      (res_ymin),
        .res_ymax      (res_ymax),
        .res_count     (res_count),
        .res_overrun   (res_overrun)
    );

    function automatic res_t model(input bit en);
        res_t r;
        int cnt = 0;
        int xmn = COLS;
        int xmx = 0;
        int ymn = ROWS;
        int ymx = 0;
        logic [23:0] p;
        if (en) begin
            for (int row = 0; row < ROWS; row++) begin
                for (int col = 0; col < COLS; col++) begin
                    p = frame_px[row][col];
                    if (p[23:16] >= 8'd160 && p[15:8] <= 8'd90 && p[7:0] <= 8'd90) begin
                        cnt++;
                        if (col < xmn) xmn = col;
                        if (col > xmx) xmx = col;
                        if (row < ymn) ymn = row;
                        if (row > ymx) ymx = row;
                    end
                end
            end
        end
        r.count = cnt;
        r.found = (cnt >= 16);
        r.xmin  = r.found ? xmn : 0;
        r.xmax  = r.found ? xmx : 0;
        r.ymin  = r.found ? ymn : 0;
        r.ymax  = r.found ? ymx : 0;
        return r;
    endfunction

    function automatic logic [63:0] pack_res(input res_t r);
        return {r.found, 11'(r.xmin), 11'(r.xmax), 10'(r.ymin), 10'(r.ymax), 21'(r.count)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_blank();
        for (int row = 0; row < ROWS; row++)
            for (int col = 0; col < COLS; col++)
                frame_px[row][col] = 24'h102030;
    endtask

    task automatic fill_random(input int dens);
        for (int row = 0; row < ROWS; row++) begin
            for (int col = 0; col < COLS; col++) begin
                if ($urandom_range(0, 99) < dens)
                    frame_px[row][col] = {8'($urandom_range(160, 255)), 8'($urandom_range(0, 90)),
                                          8'($urandom_range(0, 90))};
                else
                    frame_px[row][col] = 24'($urandom);
            end
        end
    endtask

    // vsync rises at cycle k; result is captured at k+2 and the valid bit again at k+3.
    task automatic drive_frame(input bit en);
        exp_pub       = pending;
        enable        = en;
        vid_datavalid = 1'b0;
        vid_data      = 24'h0;
        vid_v_sync    = 1'b1;
        tick();
        tick();
        cap_valid   = res_valid;
        cap_overrun = res_overrun;
        cap_res     = {res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count};
        tick();
        cap_valid_next = res_valid;
        vid_v_sync = 1'b0;
        repeat (3) tick();
        for (int row = 0; row < ROWS; row++) begin
            for (int col = 0; col < COLS; col++) begin
                vid_datavalid = 1'b1;
                vid_data      = frame_px[row][col];
                tick();
            end
            vid_datavalid = 1'b0;
            vid_data      = 24'h0;
            vid_h_sync    = 1'b1;
            tick();
            tick();
            vid_h_sync = 1'b0;
            tick();
            tick();
        end
        repeat (3) tick();
        pending = model(en);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        enable        = 1'b0;
        vid_data      = 24'h0;
        vid_datavalid = 1'b0;
        vid_h_sync    = 1'b0;
        vid_v_sync    = 1'b0;
        res_ready     = 1'b1;
        tick();
        tick();
        total++;
        if ({out_data, out_datavalid, out_h_sync, out_v_sync, res_valid, res_found, res_xmin,
             res_xmax, res_ymin, res_ymax, res_count, res_overrun} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got data=%h valid=%b count=%0d want all zero",
                     out_data, res_valid, res_count);
        end
        reset = 1'b0;
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release_valid got=%b want=0", res_valid);
        end
    endtask

    task automatic test_passthrough();
        logic [23:0] pd;
        logic pdv, phs;
        vid_data      = 24'($urandom);
        vid_datavalid = 1'($urandom);
        vid_h_sync    = 1'($urandom);
        for (int i = 0; i < 30; i++) begin
            tick();
            pd  = vid_data;
            pdv = vid_datavalid;
            phs = vid_h_sync;
            vid_data      = 24'($urandom);
            vid_datavalid = 1'($urandom);
            vid_h_sync    = 1'($urandom);
            #1;
            total++;
            if ({out_data, out_datavalid, out_h_sync, out_v_sync} !== {pd, pdv, phs, 1'b0}) begin
                bad++;
                $display("[TB] FAIL passthrough[%0d] got=%h/%b/%b want=%h/%b/%b",
                         i, out_data, out_datavalid, out_h_sync, pd, pdv, phs);
            end
        end
        vid_datavalid = 1'b0;
        vid_h_sync    = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_square();
        fill_blank();
        for (int row = 5; row <= 14; row++)
            for (int col = 10; col <= 29; col++)
                frame_px[row][col] = 24'hFF0000;
        drive_frame(1'b1);
        total++;
        if (cap_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_no_publish got=%b want=0", cap_valid);
        end
        fill_blank();
        drive_frame(1'b1);
        total++;
        if (cap_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL square_valid got=%b want=1", cap_valid);
        end
        total++;
        if (cap_res !== {1'b1, 11'd10, 11'd29, 10'd5, 10'd14, 21'd200}) begin
            bad++;
            $display("[TB] FAIL square_result got=%h want found=1 box 10/29/5/14 count=200", cap_res);
        end
        total++;
        if (cap_valid_next !== 1'b0) begin
            bad++;
            $display("[TB] FAIL square_handshake_clear got=%b want=0", cap_valid_next);
        end
    endtask

    task automatic test_min_pixels();
        fill_blank();
        for (int i = 0; i < 15; i++) frame_px[i][(i * 7) % COLS] = 24'hFF0000;
        drive_frame(1'b1);
        total++;
        if (cap_res !== 64'h0) begin
            bad++;
            $display("[TB] FAIL blank_frame got=%h want=0", cap_res);
        end
        fill_blank();
        for (int i = 0; i < 16; i++) frame_px[i][(i * 7) % COLS] = 24'hFF0000;
        drive_frame(1'b1);
        total++;
        if (cap_res !== {1'b0, 11'd0, 11'd0, 10'd0, 10'd0, 21'd15}) begin
            bad++;
            $display("[TB] FAIL fifteen_pixels got=%h want found=0 count=15", cap_res);
        end
        fill_blank();
        drive_frame(1'b1);
        total++;
        if (cap_res !== pack_res(exp_pub) || exp_pub.found !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sixteen_pixels got=%h want=%h", cap_res, pack_res(exp_pub));
        end
    endtask

    task automatic test_threshold();
        fill_blank();
        frame_px[2][3] = 24'hA05A5A;
        frame_px[2][4] = 24'h9F5A5A;
        frame_px[3][3] = 24'hA05B5A;
        frame_px[3][4] = 24'hA05A5B;
        drive_frame(1'b1);
        fill_blank();
        drive_frame(1'b1);
        total++;
        if (cap_res[20:0] !== 21'd1 || cap_res[63] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL threshold_count got=%0d want=1", cap_res[20:0]);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            fill_random($urandom_range(0, 25));
            drive_frame($urandom_range(0, 3) != 0);
            total++;
            if (cap_valid !== 1'b1 || cap_res !== pack_res(exp_pub)) begin
                bad++;
                $display("[TB] FAIL random_frame[%0d] got valid=%b res=%h want valid=1 res=%h",
                         f, cap_valid, cap_res, pack_res(exp_pub));
            end
        end
        fill_blank();
        drive_frame(1'b0);
        total++;
        if (cap_res !== pack_res(exp_pub)) begin
            bad++;
            $display("[TB] FAIL random_last got=%h want=%h", cap_res, pack_res(exp_pub));
        end
    endtask

    task automatic test_overrun();
        res_t first;
        res_ready = 1'b0;
        fill_random(20);
        drive_frame(1'b1);
        first = exp_pub;
        total++;
        if (cap_valid !== 1'b1 || cap_valid_next !== 1'b1 || cap_overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_flags got v=%b vn=%b ov=%b want 1/1/0",
                     cap_valid, cap_valid_next, cap_overrun);
        end
        total++;
        if ({res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count} !== pack_res(first)
            || res_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL held_result got=%h want=%h", {res_found, res_xmin, res_xmax,
                     res_ymin, res_ymax, res_count}, pack_res(first));
        end
        fill_random(5);
        drive_frame(1'b1);
        total++;
        if (cap_res !== pack_res(exp_pub)) begin
            bad++;
            $display("[TB] FAIL overwrite_result got=%h want=%h", cap_res, pack_res(exp_pub));
        end
        total++;
        if (cap_valid !== 1'b1 || cap_valid_next !== 1'b1 || cap_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_flags got v=%b vn=%b ov=%b want 1/1/1",
                     cap_valid, cap_valid_next, cap_overrun);
        end
        res_ready = 1'b1;
        tick();
        tick();
        total++;
        if (res_valid !== 1'b0 || res_overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_sticky got v=%b ov=%b want 0/1", res_valid, res_overrun);
        end
    endtask

    task automatic test_reset_midframe();
        res_ready     = 1'b0;
        enable        = 1'b1;
        vid_v_sync    = 1'b1;
        tick();
        tick();
        tick();
        vid_v_sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vid_datavalid = 1'b1;
            vid_data      = 24'hFF0000;
            tick();
        end
        reset = 1'b1;
        #2;
        total++;
        if ({out_data, out_datavalid, out_h_sync, out_v_sync, res_valid, res_found, res_xmin,
             res_xmax, res_ymin, res_ymax, res_count, res_overrun} !== '0) begin
            bad++;
            $display("[TB] FAIL midframe_reset got data=%h dv=%b valid=%b ov=%b want all zero",
                     out_data, out_datavalid, res_valid, res_overrun);
        end
        tick();
        tick();
        vid_datavalid = 1'b0;
        vid_data      = 24'h0;
        reset         = 1'b0;
        res_ready     = 1'b1;
        tick();
        fill_blank();
        for (int row = 0; row <= 4; row++)
            for (int col = 35; col <= 39; col++)
                frame_px[row][col] = 24'hC01020;
        drive_frame(1'b1);
        total++;
        if (cap_valid !== 1'b0 || cap_valid_next !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle got=%b/%b want=0/0", cap_valid, cap_valid_next);
        end
        fill_blank();
        drive_frame(1'b1);
        total++;
        if (cap_valid !== 1'b1
            || cap_res !== {1'b1, 11'd35, 11'd39, 10'd0, 10'd4, 21'd25}) begin
            bad++;
            $display("[TB] FAIL post_reset_frame got v=%b res=%h want found=1 box 35/39/0/4 count=25",
                     cap_valid, cap_res);
        end
    endtask

`ifdef VID_BBOX_OVERLAY_EN
    task automatic test_overlay();
        vid_datavalid = 1'b1;
        vid_data      = 24'hFF0000;
        tick();
        vid_datavalid = 1'b0;
        vid_data      = 24'h0;
        #1;
        total++;
        if (out_data !== 24'h00FF00 || out_datavalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overlay_green got=%h/%b want=00ff00/1", out_data, out_datavalid);
        end
        tick();
        tick();
    endtask
`endif

    initial begin
        pending = '{default: 0};
        exp_pub = '{default: 0};
        test_reset();
        test_passthrough();
        test_square();
        test_min_pixels();
        test_threshold();
        test_random_frames();
        test_overrun();
        test_reset_midframe();
`ifdef VID_BBOX_OVERLAY_EN
        test_overlay();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
